rect_fill: RTL and testbench

Parametrised successor to the full-screen fill engine: plots any clipped, inclusive rectangle into the VGA adapter's framebuffer at one pixel per cycle. It offers four colour modes instead of one fixed pattern. It sits between the top-level control (KEY/SW decode) and the `vga_adapter` plot port, and drives `vga_x`, `vga_y`, `vga_colour` and `vga_plot` directly.

---
 rtl/rect_fill.sv | 113 +++++++++++
 tb/tb_rect_fill.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill.sv
// rect_fill: clipped inclusive rectangle plotter, one pixel per cycle, column-major.
// Define RECT_FILL_STALL_EN to add the plot_ready back-pressure input.
module rect_fill #(
  parameter int H_RES    = 160,
  parameter int V_RES    = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y0,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [1:0]          mode,
`ifdef RECT_FILL_STALL_EN
  input  logic                plot_ready,
`endif
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);
  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;
  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);
  state_t              state_q, state_d;
  logic [X_W-1:0]      cx_q, cx_d, xb_q, xb_d;
  logic [Y_W-1:0]      cy_q, cy_d, ya_q, ya_d, yb_q, yb_d;
  logic [COLOUR_W-1:0] colour_q, colour_d, pix_colour;
  logic [1:0]          mode_q, mode_d;
  logic [X_W-1:0]      xa, xb;
  logic [Y_W-1:0]      ya, yb;
  logic                adv;
`ifdef RECT_FILL_STALL_EN
  assign adv = plot_ready;
`else
  assign adv = 1'b1;
`endif
  assign xa = (x0 > X_MAX) ? X_MAX : x0;
  assign xb = (x1 > X_MAX) ? X_MAX : x1;
  assign ya = (y0 > Y_MAX) ? Y_MAX : y0;
  assign yb = (y1 > Y_MAX) ? Y_MAX : y1;
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    xb_d     = xb_q;
    ya_d     = ya_q;
    yb_d     = yb_q;
    colour_d = colour_q;
    mode_d   = mode_q;
    case (state_q)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: begin
        xb_d     = xb;
        ya_d     = ya;
        yb_d     = yb;
        colour_d = colour;
        mode_d   = mode;
        cx_d     = xa;
        cy_d     = ya;
        state_d  = (xa > xb || ya > yb) ? DONE : FILL;
      end
      FILL: if (adv) begin
        if (cy_q != yb_q) cy_d = cy_q + Y_W'(1);
        else if (cx_q != xb_q) begin
          cy_d = ya_q;
          cx_d = cx_q + X_W'(1);
        end else state_d = DONE;
      end
      DONE: state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      xb_q     <= '0;
      ya_q     <= '0;
      yb_q     <= '0;
      colour_q <= '0;
      mode_q   <= '0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      xb_q     <= xb_d;
      ya_q     <= ya_d;
      yb_q     <= yb_d;
      colour_q <= colour_d;
      mode_q   <= mode_d;
    end
  end
  // Checkerboard inverts the base colour on odd (x+y) parity squares.
  assign pix_colour = (mode_q == 2'd0) ? colour_q :
                      (mode_q == 2'd1) ? COLOUR_W'(cx_q) :
                      (mode_q == 2'd2) ? COLOUR_W'(cy_q) :
                      (cx_q[0] ^ cy_q[0]) ? ~colour_q : colour_q;
  assign vga_x      = cx_q;
  assign vga_y      = cy_q;
  assign vga_colour = (state_q == FILL) ? pix_colour : '0;
  assign vga_plot   = (state_q == FILL) && adv;
  assign busy       = (state_q == LOAD) || (state_q == FILL);
  assign done       = (state_q == DONE);
endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill: scoreboard bench for rect_fill; expected pixels are queued before each operation.
module tb_rect_fill;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x0 = '0, x1 = '0;
  logic [6:0] y0 = '0, y1 = '0;
  logic [2:0] colour = '0;
  logic [1:0] mode = '0;
  logic       plot_ready = 1'b1;
  logic       busy, done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  pix_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         nplot = 0;

  rect_fill dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .colour(colour), .mode(mode),
`ifdef RECT_FILL_STALL_EN
    .plot_ready(plot_ready),
`endif
    .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && vga_plot) begin
      pix_t e;
      nplot++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL plot_unexpected: got (%0d,%0d) colour %0d, required no plot", vga_x, vga_y, vga_colour);
      end else begin
        e = exp_q.pop_front();
        if ({vga_x, vga_y, vga_colour} !== e) begin
          errors++;
          $display("FAIL plot_pixel: got (%0d,%0d) colour %0d, required (%0d,%0d) colour %0d",
                   vga_x, vga_y, vga_colour, e.x, e.y, e.c);
        end
      end
    end
  end

  function automatic logic [2:0] model_colour(input int x, input int y, input logic [1:0] m, input logic [2:0] c);
    case (m)
      2'd0: return c;
      2'd1: return 3'(x);
      2'd2: return 3'(y);
      default: return ((x ^ y) & 1) ? ~c : c;
    endcase
  endfunction

  task automatic push_rect(input int xa, input int xb, input int ya, input int yb, input logic [1:0] m, input logic [2:0] c);
    for (int x = xa; x <= xb; x++)
      for (int y = ya; y <= yb; y++)
        exp_q.push_back({8'(x), 7'(y), model_colour(x, y, m, c)});
  endtask

  task automatic run_op(input string name, input int ax0, input int ax1, input int ay0, input int ay1,
                        input logic [2:0] c, input logic [1:0] m, input int exp_done);
    int cyc;
    @(negedge clk);
    x0 = 8'(ax0); x1 = 8'(ax1); y0 = 7'(ay0); y1 = 7'(ay1); colour = c; mode = m;
    start = 1'b1;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_busy_load: got %b, required 1", name, busy);
        end
      end
    end while (!done && cyc < 25000);
    checks++;
    if (cyc != exp_done) begin
      errors++;
      $display("FAIL %s_done_cycle: got %0d, required %0d", name, cyc, exp_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_plots: got %0d left over, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic end_op(input string name);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: got done=%b busy=%b, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset;
    int base;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({vga_plot, busy, done, vga_x, vga_y, vga_colour} !== '0) begin
      errors++;
      $display("FAIL reset_state: got plot=%b busy=%b done=%b x=%0d y=%0d col=%0d, required all 0",
               vga_plot, busy, done, vga_x, vga_y, vga_colour);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base = nplot;
    push_rect(0, 159, 0, 119, 2'd0, 3'd1);
    @(negedge clk);
    x0 = 8'd0; x1 = 8'd159; y0 = 7'd0; y1 = 7'd119; colour = 3'd1; mode = 2'd0;
    start = 1'b1;
    for (int i = 0; i < 200 && nplot < base + 37; i++) begin
      @(negedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vga_plot, busy, done, vga_x, vga_y} !== '0) begin
      errors++;
      $display("FAIL reset_midfill: got plot=%b busy=%b done=%b x=%0d y=%0d after %0d plots, required all 0",
               vga_plot, busy, done, vga_x, vga_y, nplot - base);
    end
    exp_q.delete();
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    base = nplot;
    repeat (6) @(negedge clk);
    checks++;
    if (nplot != base || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_plots: got %0d plots busy=%b, required 0 plots busy=0", nplot - base, busy);
    end
  endtask

  task automatic test_small;
    push_rect(2, 4, 5, 6, 2'd0, 3'd5);
    run_op("small", 2, 4, 5, 6, 3'd5, 2'd0, 8);
    end_op("small");
  endtask

  task automatic test_clip;
    int base;
    push_rect(158, 159, 118, 119, 2'd2, 3'd0);
    run_op("clip", 158, 200, 118, 127, 3'd0, 2'd2, 6);
    end_op("clip");
    base = nplot;
    run_op("empty", 10, 9, 0, 0, 3'd3, 2'd0, 2);
    checks++;
    if (nplot != base) begin
      errors++;
      $display("FAIL empty_plots: got %0d, required 0", nplot - base);
    end
    end_op("empty");
  endtask

  task automatic test_modes;
    int base;
    base = nplot;
    push_rect(0, 159, 0, 119, 2'd1, 3'd0);
    run_op("full_mode1", 0, 159, 0, 119, 3'd0, 2'd1, 19202);
    checks++;
    if (nplot - base != 19200) begin
      errors++;
      $display("FAIL full_mode1_count: got %0d, required 19200", nplot - base);
    end
    end_op("full_mode1");
    push_rect(0, 1, 0, 1, 2'd3, 3'd2);
    run_op("checker", 0, 1, 0, 1, 3'd2, 2'd3, 6);
    end_op("checker");
  endtask

  task automatic test_back_to_back;
    int base;
    push_rect(20, 22, 30, 30, 2'd3, 3'd6);
    run_op("hs_first", 20, 22, 30, 30, 3'd6, 2'd3, 5);
    base = nplot;
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || nplot != base) begin
      errors++;
      $display("FAIL hs_hold: got done=%b plots=%0d, required done=1 plots=0", done, nplot - base);
    end
    end_op("hs_first");
    push_rect(20, 22, 30, 30, 2'd3, 3'd6);
    run_op("hs_second", 20, 22, 30, 30, 3'd6, 2'd3, 5);
    end_op("hs_second");
  endtask

`ifdef RECT_FILL_STALL_EN
  task automatic test_stall;
    int cyc;
    int base;
    base = nplot;
    push_rect(50, 51, 60, 61, 2'd0, 3'd4);
    @(negedge clk);
    x0 = 8'd50; x1 = 8'd51; y0 = 7'd60; y1 = 7'd61; colour = 3'd4; mode = 2'd0;
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    forever begin
      #1 plot_ready = cyc[0];
      @(negedge clk);
      if (done || cyc >= 100) break;
      @(posedge clk);
      cyc++;
    end
    plot_ready = 1'b1;
    checks++;
    if (cyc != 10 || nplot - base != 4) begin
      errors++;
      $display("FAIL stall_done: got cycle %0d plots %0d, required cycle 10 plots 4", cyc, nplot - base);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_missing: got %0d left over, required 0", exp_q.size());
      exp_q.delete();
    end
    end_op("stall");
  endtask
`endif

  initial begin
    test_reset();
    test_small();
    test_clip();
    test_modes();
    test_back_to_back();
`ifdef RECT_FILL_STALL_EN
    test_stall();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
